// File: rtl/reverse_sequence.sv
// Segment reverser: buffers complement bases until a segment ends, then replays
// them newest-first with a one-cycle turnaround and valid/ready flow control.
module reverse_sequence #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          write,
  input  logic [7:0]    in_base,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [7:0]    out_base,
  output logic          out_last,
  input  logic          out_ready,
  output logic [AW:0]   seg_len,
  output logic          bad_seen
);

  // state   | meaning
  // S_FILL  | accepting bases into the stack
  // S_DRAIN | emitting stored bases newest-first
  typedef enum logic {S_FILL, S_DRAIN} state_t;

  localparam logic [7:0]  LP_BAD_CODE = 8'hF1;
  localparam logic [7:0]  LP_IDLE     = 8'h1F;
  localparam logic [AW:0] LP_FULL     = (AW+1)'(DEPTH - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [7:0]    r_mem [DEPTH];
  logic [AW:0]   r_count;
  logic [AW-1:0] r_rd_ptr;
  logic          r_out_valid;
  logic          r_out_last;
  logic [7:0]    r_out_base;
  logic [AW:0]   r_seg_len;
  logic          r_bad_seen;
  logic          r_bad_acc;

  logic          w_accept;
  logic          w_seg_end;
  logic          w_xfer;
  logic          w_done;
  logic [AW-1:0] w_wr_ptr;
  logic [AW-1:0] w_rd_next;
  logic          w_in_bad;

  assign w_accept  = write && (r_state == S_FILL);
  assign w_seg_end = w_accept && (in_last || (r_count == LP_FULL));
  assign w_xfer    = r_out_valid && out_ready;
  assign w_done    = w_xfer && r_out_last;
  assign w_wr_ptr  = r_count[AW-1:0];
  assign w_rd_next = r_rd_ptr - 1'b1;
  assign w_in_bad  = (in_base == LP_BAD_CODE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL:  if (w_seg_end) w_state_next = S_DRAIN;
      S_DRAIN: if (w_done)    w_state_next = S_FILL;
      default: w_state_next = S_FILL;
    endcase
  end

  // Storage is never cleared; the count alone defines what is valid.
  always_ff @(posedge clock) begin
    if (w_accept) r_mem[w_wr_ptr] <= in_base;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_base  <= LP_IDLE;
      r_seg_len   <= '0;
      r_bad_seen  <= 1'b0;
      r_bad_acc   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_count <= r_count + 1'b1;
        if (w_seg_end) begin
          // Newest base bypasses the stack so it appears one cycle after its write.
          r_out_valid <= 1'b1;
          r_out_base  <= in_base;
          r_out_last  <= (r_count == '0);
          r_rd_ptr    <= w_wr_ptr;
          r_seg_len   <= r_count + 1'b1;
          r_bad_seen  <= r_bad_acc || w_in_bad;
          r_bad_acc   <= 1'b0;
        end else if (w_in_bad) begin
          r_bad_acc <= 1'b1;
        end
      end
      if (w_xfer) begin
        if (r_out_last) begin
          r_count     <= '0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_out_base  <= LP_IDLE;
        end else begin
          r_rd_ptr   <= w_rd_next;
          r_out_base <= r_mem[w_rd_next];
          r_out_last <= (w_rd_next == '0);
        end
      end
    end
  end

  assign in_ready  = (r_state == S_FILL);
  assign out_valid = r_out_valid;
  assign out_base  = r_out_base;
  assign out_last  = r_out_last;
  assign seg_len   = r_seg_len;
  assign bad_seen  = r_bad_seen;

endmodule

// File: tb/tb_reverse_sequence.sv
// Self-checking bench for reverse_sequence: directed segments plus randomized
// segments checked against a queue-based LIFO reference.
module tb_reverse_sequence;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          write;
  logic [7:0]    in_base;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_base;
  logic          out_last;
  logic          out_ready;
  logic [AW:0]   seg_len;
  logic          bad_seen;

  int total = 0;
  int bad   = 0;

  reverse_sequence #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset(reset), .write(write), .in_base(in_base),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_base(out_base), .out_last(out_last), .out_ready(out_ready),
    .seg_len(seg_len), .bad_seen(bad_seen)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Reference: a segment is emitted newest-first.
  function automatic void model_reverse(input logic [7:0] q[$], output logic [7:0] r[$]);
    r = {};
    foreach (q[i]) r.push_front(q[i]);
  endfunction

  function automatic bit model_has_bad(input logic [7:0] q[$]);
    foreach (q[i]) if (q[i] == 8'hF1) return 1'b1;
    return 1'b0;
  endfunction

  // Drives one segment starting at a negedge; returns at the negedge after the final write.
  task automatic send_segment(input logic [7:0] bases[$], input bit mark_last, input bit gaps);
    for (int i = 0; i < bases.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          write = 1'b0;
          @(negedge clock);
        end
      end
      write   = 1'b1;
      in_base = bases[i];
      in_last = mark_last && (i == bases.size() - 1);
      @(negedge clock);
    end
    write   = 1'b0;
    in_last = 1'b0;
  endtask

  // Collects transfers until out_last transfers; returns at the negedge after it.
  task automatic drain_collect(input bit rand_ready, output logic [7:0] outs[$],
                               output bit lasts[$], output int cycles, output bit timeout);
    outs = {}; lasts = {}; cycles = 0; timeout = 1'b1;
    for (int c = 0; c < 8*DEPTH + 20; c++) begin
      out_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      cycles++;
      if (out_valid && out_ready) begin
        outs.push_back(out_base);
        lasts.push_back(out_last);
      end
      @(negedge clock);
      if (lasts.size() > 0 && lasts[lasts.size()-1]) begin
        timeout = 1'b0;
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [18:0] act, exp;
    @(negedge clock);
    act = {in_ready, out_valid, out_last, out_base, seg_len, bad_seen};
    exp = {1'b1, 1'b0, 1'b0, 8'h1F, 7'd0, 1'b0};
    total++;
    if (act !== exp) begin bad++; $display("FAIL reset_state actual=%h required=%h", act, exp); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_acg();
    logic [7:0] q[$], exp[$], outs[$];
    bit lasts[$], to;
    int cyc;
    logic [11:0] act_v, exp_v;
    q = {"A", "C", "G"};
    model_reverse(q, exp);
    send_segment(q, 1'b1, 1'b0);
    total++;
    if (!(out_valid === 1'b1 && out_base === "G")) begin
      bad++; $display("FAIL acg_latency actual=valid %b base %h required=valid 1 base %h", out_valid, out_base, 8'h47);
    end
    drain_collect(1'b0, outs, lasts, cyc, to);
    total++;
    if (to || outs.size() != 3 || cyc != 3) begin
      bad++; $display("FAIL acg_count actual=%0d outs in %0d cycles timeout %b required=3 in 3", outs.size(), cyc, to);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (outs[i] !== exp[i] || lasts[i] !== (i == 2)) begin
          bad++; $display("FAIL acg_out[%0d] actual=%h last %b required=%h last %b", i, outs[i], lasts[i], exp[i], (i == 2));
        end
      end
    end
    total++;
    if (seg_len !== 7'd3 || bad_seen !== 1'b0) begin
      bad++; $display("FAIL acg_meta actual=len %0d bad %b required=len 3 bad 0", seg_len, bad_seen);
    end
    act_v = {in_ready, out_valid, out_last, out_base, 1'b0};
    exp_v = {1'b1, 1'b0, 1'b0, 8'h1F, 1'b0};
    total++;
    if (act_v !== exp_v) begin bad++; $display("FAIL acg_back_to_fill actual=%h required=%h", act_v, exp_v); end
  endtask

  task automatic test_single();
    logic [7:0] q[$], outs[$];
    bit lasts[$], to;
    int cyc;
    q = {"T"};
    send_segment(q, 1'b1, 1'b0);
    total++;
    if (!(out_valid === 1'b1 && out_base === "T" && out_last === 1'b1 && seg_len === 7'd1)) begin
      bad++; $display("FAIL single_present actual=v%b b%h l%b len%0d required=v1 b54 l1 len1", out_valid, out_base, out_last, seg_len);
    end
    // Upstream keeps pushing through the whole drain, including the final transfer.
    write = 1'b1; in_base = "Z"; in_last = 1'b1;
    drain_collect(1'b0, outs, lasts, cyc, to);
    write = 1'b0; in_last = 1'b0;
    total++;
    if (to || outs.size() != 1 || outs[0] !== "T" || lasts[0] !== 1'b1) begin
      bad++; $display("FAIL single_out actual=%0d outs first %h timeout %b required=1 out 54 last", outs.size(), (outs.size() > 0) ? outs[0] : 8'h00, to);
    end
    total++;
    if (out_valid !== 1'b0 || out_base !== 8'h1F || in_ready !== 1'b1) begin
      bad++; $display("FAIL single_fill actual=v%b b%h r%b required=v0 b1f r1", out_valid, out_base, in_ready);
    end
    q = {"C"};
    send_segment(q, 1'b1, 1'b0);
    total++;
    if (!(out_base === "C" && out_last === 1'b1 && seg_len === 7'd1)) begin
      bad++; $display("FAIL no_overlap actual=b%h l%b len%0d required=b43 l1 len1", out_base, out_last, seg_len);
    end
    drain_collect(1'b0, outs, lasts, cyc, to);
    total++;
    if (to || outs.size() != 1) begin bad++; $display("FAIL no_overlap_drain actual=%0d outs required=1", outs.size()); end
  endtask

  task automatic test_full();
    logic [7:0] q[$], exp[$], outs[$];
    bit lasts[$], to;
    int cyc, errs;
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back(8'($urandom_range(255)));
    model_reverse(q, exp);
    send_segment(q, 1'b0, 1'b0);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_base !== q[DEPTH-1]) begin
      bad++; $display("FAIL full_enter actual=r%b v%b b%h required=r0 v1 b%h", in_ready, out_valid, out_base, q[DEPTH-1]);
    end
    write = 1'b1; in_base = 8'hAA; in_last = 1'b1;
    drain_collect(1'b0, outs, lasts, cyc, to);
    write = 1'b0; in_last = 1'b0;
    total++;
    if (to || outs.size() != DEPTH || cyc != DEPTH) begin
      bad++; $display("FAIL full_count actual=%0d outs %0d cycles required=%0d", outs.size(), cyc, DEPTH);
    end else begin
      errs = 0;
      for (int i = 0; i < DEPTH; i++) if (outs[i] !== exp[i] || lasts[i] !== (i == DEPTH-1)) errs++;
      total++;
      if (errs != 0) begin bad++; $display("FAIL full_order actual=%0d wrong entries required=0", errs); end
    end
    total++;
    if (seg_len !== 7'(DEPTH) || bad_seen !== model_has_bad(q)) begin
      bad++; $display("FAIL full_meta actual=len %0d bad %b required=len %0d bad %b", seg_len, bad_seen, DEPTH, model_has_bad(q));
    end
  endtask

  task automatic test_bad_code();
    logic [7:0] q[$], exp[$], outs[$];
    bit lasts[$], to;
    int cyc;
    q = {"A", 8'hF1, "T"};
    model_reverse(q, exp);
    send_segment(q, 1'b1, 1'b0);
    drain_collect(1'b0, outs, lasts, cyc, to);
    total++;
    if (to || outs.size() != 3 || outs[0] !== exp[0] || outs[1] !== exp[1] || outs[2] !== exp[2]) begin
      bad++; $display("FAIL bad_passthru actual=%0d outs timeout %b required=54 f1 41", outs.size(), to);
    end
    total++;
    if (bad_seen !== 1'b1 || seg_len !== 7'd3) begin
      bad++; $display("FAIL bad_flag_set actual=bad %b len %0d required=bad 1 len 3", bad_seen, seg_len);
    end
    q = {"G", "G"};
    send_segment(q, 1'b1, 1'b0);
    total++;
    if (bad_seen !== 1'b0 || seg_len !== 7'd2) begin
      bad++; $display("FAIL bad_flag_clear actual=bad %b len %0d required=bad 0 len 2", bad_seen, seg_len);
    end
    drain_collect(1'b0, outs, lasts, cyc, to);
  endtask

  task automatic test_stall();
    logic [7:0] q[$], exp[$];
    bit pat[$];
    int n, c;
    bit done;
    q = {"A", "C", "G", "T"};
    model_reverse(q, exp);
    pat = {1'b1, 1'b0, 1'b0, 1'b1};
    send_segment(q, 1'b1, 1'b0);
    n = 0; done = 1'b0;
    for (c = 0; c < 20 && !done; c++) begin
      out_ready = (c < pat.size()) ? pat[c] : 1'b1;
      total++;
      if (out_valid !== 1'b1 || out_base !== exp[n] || out_last !== (n == 3)) begin
        bad++; $display("FAIL stall_present[c%0d] actual=v%b b%h l%b required=v1 b%h l%b", c, out_valid, out_base, out_last, exp[n], (n == 3));
      end
      if (out_ready) begin
        if (n == 3) done = 1'b1;
        n++;
      end
      @(negedge clock);
    end
    out_ready = 1'b1;
    total++;
    if (!done || c != 6 || out_valid !== 1'b0) begin
      bad++; $display("FAIL stall_total actual=done %b cycles %0d valid %b required=done 1 cycles 6 valid 0", done, c, out_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] q[$], outs[$];
    bit lasts[$], to;
    int cyc;
    logic [18:0] act, exp;
    q = {"A", "C", "G", "T"};
    send_segment(q, 1'b1, 1'b0);
    out_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    #1;
    act = {in_ready, out_valid, out_last, out_base, seg_len, bad_seen};
    exp = {1'b1, 1'b0, 1'b0, 8'h1F, 7'd0, 1'b0};
    total++;
    if (act !== exp) begin bad++; $display("FAIL reset_mid_drain actual=%h required=%h", act, exp); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    q = {"G", "A"};
    send_segment(q, 1'b1, 1'b0);
    drain_collect(1'b0, outs, lasts, cyc, to);
    total++;
    if (to || outs.size() != 2 || outs[0] !== "A" || outs[1] !== "G" || lasts[1] !== 1'b1 || seg_len !== 7'd2) begin
      bad++; $display("FAIL after_reset_seg actual=%0d outs len %0d required=2 outs A,G len 2", outs.size(), seg_len);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$], exp[$], outs[$];
    logic [7:0] alpha[$];
    bit lasts[$], to;
    int cyc, len, errs;
    alpha = {"A", "C", "G", "T", 8'hF1};
    for (int s = 0; s < 8; s++) begin
      len = (s == 0) ? DEPTH : int'($urandom_range(DEPTH, 1));
      q = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(9) == 0) q.push_back(alpha[4]);
        else q.push_back(alpha[$urandom_range(3)]);
      end
      model_reverse(q, exp);
      send_segment(q, (len < DEPTH) ? 1'b1 : 1'($urandom_range(1)), 1'b1);
      drain_collect(1'b1, outs, lasts, cyc, to);
      errs = 0;
      if (outs.size() != len) errs++;
      else for (int i = 0; i < len; i++) if (outs[i] !== exp[i] || lasts[i] !== (i == len-1)) errs++;
      total++;
      if (to || errs != 0) begin
        bad++; $display("FAIL rand_seg%0d actual=%0d outs %0d errs timeout %b required=%0d outs 0 errs", s, outs.size(), errs, to, len);
      end
      total++;
      if (seg_len !== 7'(len) || bad_seen !== model_has_bad(q)) begin
        bad++; $display("FAIL rand_meta%0d actual=len %0d bad %b required=len %0d bad %b", s, seg_len, bad_seen, len, model_has_bad(q));
      end
    end
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; in_base = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    test_reset();
    test_acg();
    test_single();
    test_full();
    test_bad_code();
    test_stall();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reverse_sequence.md
REVERSE_SEQUENCE -- requirements
Module: reverse_sequence

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning maximum bases per segment (power of two, >= 2).
REQ-002 The block SHALL have parameter AW, default 6, meaning log2(DEPTH).
REQ-003 The block SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port write  input  1  upstream base valid.
REQ-006 The block SHALL have port in_base  input  [0:7]  ASCII complement base from the complement stage.
REQ-007 The block SHALL have port in_last  input  1  marks the final base of a segment; sampled only with an accepted write.
REQ-008 The block SHALL have port in_ready  output  1  block can accept a base this cycle.
REQ-009 The block SHALL have port out_valid  output  1  out_base is valid.
REQ-010 The block SHALL have port out_base  output  [0:7]  reversed-order base.
REQ-011 The block SHALL have port out_last  output  1  marks the final emitted base of a segment.
REQ-012 The block SHALL have port out_ready  input  1  downstream accepts out_base this cycle.
REQ-013 The block SHALL have port seg_len  output  [0:AW]  number of bases in the segment being drained.
REQ-014 The block SHALL have port bad_seen  output  1  segment being drained contained at least one 8'hF1 code.

Function
REQ-015 The block SHALL implement two states: FILL (accepting) and DRAIN (emitting); in_ready SHALL be 1 exactly in FILL.
REQ-016 An accepted write (write && in_ready) SHALL store in_base at the stack pointer and increment the stored count.
REQ-017 A write while in_ready=0 SHALL be ignored, with no state change.
REQ-018 An accepted write with in_last=1 SHALL move the block to DRAIN at the next edge.
REQ-019 An accepted write that brings the count to DEPTH with in_last=0 SHALL also move the block to DRAIN (implicit segment end).
REQ-020 The last-write-to-output latency SHALL be one cycle: on the cycle after that write, out_valid=1 and out_base=the most recently stored base.
REQ-021 Transfer SHALL occur when out_valid && out_ready; out_base/out_last SHALL hold stable while out_valid && !out_ready.
REQ-022 After a transfer, the next cycle SHALL present the next-older stored base (LIFO order), sustaining one base per cycle with out_ready held high.
REQ-023 out_last SHALL be 1 only while the oldest (first-written) base is presented.
REQ-024 A transfer with out_last=1 SHALL return the block to FILL at the next edge, with count=0, out_valid=0, out_last=0, and out_base=8'h1F.
REQ-025 seg_len SHALL be loaded with the final segment count on entry to DRAIN and held until the next DRAIN entry; a single-base segment SHALL give seg_len=1 and one output with out_last=1.
REQ-026 bad_seen SHALL be set on entry to DRAIN if any stored base of that segment equalled 8'hF1, and held until the next DRAIN entry; bases SHALL pass through unaltered, including 8'hF1.
REQ-027 Segments SHALL never overlap; no input SHALL be accepted on the cycle the last output transfers.

Reset
REQ-028 Reset SHALL asynchronously force FILL, count=0, in_ready=1, out_valid=0, out_last=0, out_base=8'h1F, seg_len=0, and bad_seen=0.
REQ-029 Reset during FILL or DRAIN SHALL discard all stored bases; storage contents need no clearing.

Verification
REQ-030 The bench SHALL cover: write "A","C","G" (last on "G"), out_ready=1 -> outputs "G","C","A" on consecutive cycles starting 1 cycle after the "G" write, out_last only on "A", seg_len=3, bad_seen=0.
REQ-031 The bench SHALL cover: a single write "T" with in_last=1 -> one output "T" with out_last=1, seg_len=1, then FILL with out_base=8'h1F.
REQ-032 The bench SHALL cover: 64 writes with in_last=0 -> in_ready drops after the 64th, 64 outputs in reverse order, out_last on the first-written base, seg_len=64, and a 65th write attempted during DRAIN is ignored.
REQ-033 The bench SHALL cover: segment "A",8'hF1,"T" -> outputs "T",8'hF1,"A" with bad_seen=1; a following clean segment -> bad_seen=0.
REQ-034 The bench SHALL cover: out_ready toggled 1,0,0,1 during DRAIN -> out_base stable while stalled, and no base lost or duplicated.
REQ-035 The bench SHALL cover: reset asserted mid-DRAIN -> out_valid=0 and out_base=8'h1F immediately, in_ready=1, and the next segment reverses correctly with no stale bases.
